apb_reg_responder: RTL
======================

// Module: apb_reg_responder
// PURPOSE
//  APB4 completer (responder) backed by a small register file. Serves transfers issued by an
//  APB requester on clk_i, inserting a fixed number of wait states per transfer. Applies
//  byte-strobe writes and flags invalid accesses with pslverr. Exposes register contents to
//  the core, e.g. UART control/status.
// PARAMETERS
//  ADDR_WIDTH   32     paddr width
//  DATA_WIDTH   32     data width; multiple of 8
//  NUM_REGS     8      number of registers; power of 2, >=2; word-aligned from address 0
//  WAIT_CYCLES  0      access-phase cycles with pready low before completion (0..15)
//  RO_MASK      '0     NUM_REGS-bit map; bit i=1 -> reg i read-only, reads status_i slice i
//  RESET_VALUE  '0     reset value of every writable register
// PORTS
//  arst_ni    in   1                     asynchronous reset, active low
//  clk_i      in   1                     clock
//  psel_i     in   1                     peripheral select
//  penable_i  in   1                     enable (access phase)
//  paddr_i    in   ADDR_WIDTH            byte address
//  pwrite_i   in   1                     1=write, 0=read
//  pwdata_i   in   DATA_WIDTH            write data
//  pstrb_i    in   DATA_WIDTH/8          write byte strobes
//  pready_o   out  1                     transfer complete
//  prdata_o   out  DATA_WIDTH            read data
//  pslverr_o  out  1                     transfer error
//  regs_o     out  NUM_REGS*DATA_WIDTH   writable register contents; reg i at [i*DW +: DW]
//  status_i   in   NUM_REGS*DATA_WIDTH   read-only register sources; slices unused if RO bit=0
// BEHAVIOUR
//  Reset (arst_ni low, any time, including mid-transfer)
//   - State goes to IDLE and the counter to 0.
//   - pready_o, pslverr_o and prdata_o are 0.
//   - Every writable register takes RESET_VALUE. No pending write commits.
//  FSM IDLE / ACCESS, with a 4-bit wait counter cnt
//   - IDLE: at an edge with psel_i=1, penable_i=0 (setup) -> ACCESS, cnt<=WAIT_CYCLES.
//   - ACCESS, psel_i=1, penable_i=1, cnt!=0: cnt decrements at each edge.
//   - ACCESS, psel_i=1, penable_i=1, cnt==0: the edge completes the transfer -> IDLE.
//   - ACCESS, psel_i=0 (aborted transfer): -> IDLE. No write and no error.
//  pready_o = (state==ACCESS) & (cnt==0), decoded from registers only.
//   - Access phase lasts WAIT_CYCLES+1 cycles.
//   - Back-to-back: the cycle after completion is the next setup phase, handled from IDLE.
//  Decode
//   - Index = paddr_i[$clog2(NUM_REGS)+1:2].
//   - err = (paddr_i >= NUM_REGS*4) | (paddr_i[1:0]!=0) | (pwrite_i & RO_MASK[index]).
//   - pslverr_o = pready_o & err; it is 0 outside the completion cycle.
//  Write
//   - Commits at the completion edge when pwrite_i=1 and err=0.
//   - Byte lane b is updated only where pstrb_i[b]=1. pstrb_i==0 gives no change and no error.
//   - An erroring write leaves every register unchanged.
//  Read
//   - prdata_o = pready_o & ~pwrite_i & ~err ? selected value : 0.
//   - Selected value is the register, or the status_i slice when RO.
//   - Reads have no side effects.
//  regs_o
//   - Reflects a write from the cycle after the commit edge.
//   - RO slots of regs_o read as 0.
//  Inputs are assumed APB-compliant except the psel_i abort, which is tolerated as above.
// TESTING
//  1 Reset: assert arst_ni mid-access with WAIT_CYCLES=3.
//    -> pready_o/pslverr_o/prdata_o=0 immediately; regs_o=RESET_VALUE; no write committed.
//  2 WAIT_CYCLES=0: write 0xDEADBEEF to 0x4 with pstrb=0xF, then read 0x4.
//    -> pready_o high in the first access cycle; prdata_o=0xDEADBEEF; pslverr_o=0.
//  3 WAIT_CYCLES=2: read 0x0.
//    -> pready_o low for exactly 2 access cycles, then high for 1; the transfer takes 4 cycles.
//  4 Write 0xFFFFFFFF to 0x8, then write 0x11223344 with pstrb=0b0101.
//    -> reg2=0xFF22FF44. Also write 0xAAAAAAAA with pstrb=0 -> reg2 unchanged.
//  5 Write/read at 0x20 (NUM_REGS=8), then at 0x2.
//    -> pslverr_o=1 with pready_o; prdata_o=0; no register change.
//    RO_MASK[1]=1: write 0x4 -> pslverr_o=1; read 0x4 -> status_i slice 1.
//  6 Drop psel_i after 1 access cycle of a write (WAIT_CYCLES=3), then issue a back-to-back read.
//    -> No write; the FSM returns to IDLE; the following transfer completes normally.

Source files
------------

// File: rtl/apb_reg_responder_if.sv
// APB4 requester/completer bus bundle for apb_reg_responder.
interface apb_reg_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  psel_i;
  logic                  penable_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic                  pwrite_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [STRB_WIDTH-1:0] pstrb_i;
  logic                  pready_o;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pslverr_o;

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_reg_responder.sv
// APB4 completer over a small register file with fixed wait states,
// byte-strobe writes, read-only status slots and error signalling.
module apb_reg_responder #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  apb_reg_responder_if.slave             apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REGS);
  localparam int unsigned CNT_WIDTH  = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]   idx;
  logic                   err;
  logic                   ready;
  logic                   commit;
  logic [DATA_WIDTH-1:0]  rd_val;

  // Address decode and error classification
  assign idx    = apb.paddr_i[IDX_WIDTH+1:2];
  assign err    = (apb.paddr_i >= ADDR_WIDTH'(NUM_REGS * 4))
                | (apb.paddr_i[1:0] != 2'b00)
                | (apb.pwrite_i & RO_MASK[idx]);
  assign ready  = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign commit = ready & apb.psel_i & apb.penable_i & apb.pwrite_i & ~err;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dropping psel during the access phase abandons the transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (apb.psel_i && !apb.penable_i) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_WIDTH'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (!apb.psel_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (apb.penable_i) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Writable slots hold flops; read-only slots expose zero on regs_o
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
          q <= RESET_VALUE;
        end else if (commit && (idx == IDX_WIDTH'(i))) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (apb.pstrb_i[b]) q[b*8 +: 8] <= apb.pwdata_i[b*8 +: 8];
          end
        end
      end
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end
  end

  assign rd_val = RO_MASK[idx] ? status_i[idx*DATA_WIDTH +: DATA_WIDTH]
                               : regs_o[idx*DATA_WIDTH +: DATA_WIDTH];

  assign apb.pready_o  = ready;
  assign apb.pslverr_o = ready & err;
  assign apb.prdata_o  = (ready & ~apb.pwrite_i & ~err) ? rd_val : '0;
endmodule
